adc_lvds_word_serializer: RTL
=============================

Name: adc_lvds_word_serializer

Overview:
- Transmit-side counterpart of the ADC LVDS deserializer/frame-detect path.
- Takes parallel ADC-style words over a valid/ready handshake and shifts them out MSB-first, one bit per CLK, on a data line.
- Drives a matching frame line alongside the data so the receive chain can be exercised in loopback and simulation.
- Supports training, idle fill and on-demand one-bit slips, which stress receiver bitslip alignment.

Parameters:
- WORD_W, 8: bits per word; legal range 2..8.
- FRAME_PATTERN, 8'hF0: frame line pattern per word, MSB sent first; low WORD_W bits used.
- TRAIN_PATTERN, 8'hA5: word sent during training and as idle fill.
- TRAIN_WORDS, 16: training words sent after reset; 0 is legal.

Ports:
- CLK  in  1  bit clock; single clock domain, all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- en_i  in  1  clock enable; when low, all state and outputs hold.
- in_data_i  in  WORD_W  parallel word to send.
- in_valid_i  in  1  in_data_i valid.
- in_ready_o  out  1  serializer accepts a word this cycle.
- slip_i  in  1  request a one-bit alignment slip.
- sdata_o  out  1  serial data, MSB first.
- frame_o  out  1  serial frame, word-aligned with sdata_o.
- word_start_o  out  1  high while the first (MSB) bit of a word is on sdata_o.
- train_done_o  out  1  high once training has completed.
- underrun_o  out  1  one-cycle pulse when idle fill replaces missing data.

Behaviour:
- Reset values (RST_N low, asynchronous):
  - sdata_o, frame_o, in_ready_o, word_start_o, train_done_o, underrun_o = 0.
  - state = TRAIN, bit_cnt = WORD_W-1, train counter = 0, slip_pend = 0.
- States: TRAIN and RUN.
  - TRAIN → RUN at the boundary that follows the last training word.
  - With TRAIN_WORDS = 0, the first boundary is already a RUN boundary.
- Boundary cycle: bit_cnt == WORD_W-1, en_i high, no stretch in progress. In a boundary cycle the shift register loads the selected word and the frame register loads FRAME_PATTERN.
- Next cycle after a boundary: sdata_o = word[WORD_W-1], frame_o = FRAME_PATTERN[WORD_W-1], word_start_o = 1, bit_cnt = 0. Each later cycle shifts one bit and increments bit_cnt.
- The first cycle after reset release (with en_i high) is a boundary.
- Word selection at a boundary:
  - TRAIN: TRAIN_PATTERN.
  - RUN with a transfer: in_data_i.
  - RUN without a transfer: TRAIN_PATTERN, and underrun_o pulses on the next cycle.
  - Exception: no underrun pulse on the very first RUN boundary.
- Handshake:
  - in_ready_o is registered and high only during RUN boundary cycles. It is never high in TRAIN or during a stretch cycle.
  - A transfer occurs when in_valid_i && in_ready_o.
  - Latency: the accepted word's MSB appears on sdata_o one cycle after the transfer. The full word is out WORD_W cycles after that.
- train_done_o: set in the cycle in_ready_o first rises; sticky until reset.
- Slip:
  - A slip_i pulse sets slip_pend.
  - At the next boundary, instead of loading, insert one stretch cycle: sdata_o and frame_o repeat their previous bit, word_start_o = 0, in_ready_o = 0. Then clear slip_pend; the following cycle is a normal boundary.
  - Net effect: a one-bit shift of all later words relative to the receiver.
  - slip_i arriving while slip_pend is set is ignored (at most one stretch per boundary).
  - slip_i asserted in a boundary cycle: that boundary proceeds normally, and the stretch applies at the next boundary.
- en_i low: nothing advances, including slip capture; in_ready_o is forced low.
- Reset mid-word: the partial word is discarded, and training restarts.

Optional Feature:
- Macro: ADC_TX_PRBS_EN.
- Defined:
  - Adds input prbs_sel_i.
  - While it is high in RUN, each boundary loads the next WORD_W bits of PRBS-7 (x^7+x^6+1, seed 7'h7F, MSB-first).
  - in_ready_o stays low and underrun_o stays 0 in this mode.
  - The PRBS state advances only at boundaries.
- Undefined: the prbs_sel_i port and the PRBS logic are absent; behaviour is as above.

Decomposition:
- Shared package adc_lvds_pkg holds:
  - the WORD_W default;
  - FRAME_PATTERN and TRAIN_PATTERN defaults;
  - the state enum (TRAIN, RUN);
  - the PRBS-7 polynomial and seed constants.
- Sub-module prbs7_gen (parallel WORD_W-bit step, advance enable) is instantiated only under ADC_TX_PRBS_EN.

Test Plan:
- Training: reset with TRAIN_WORDS=2, in_valid_i=0. Expect 16 bits of 1010_0101 ×2 on sdata_o and frame 1111_0000 per word. in_ready_o first high at cycle 16 after release; train_done_o rises then.
- Streaming: after training, send words 8'h3C then 8'hC3 back-to-back with in_valid_i held. Expect sdata_o = 0011_1100_1100_0011 with no gaps and word_start_o every 8 cycles. No underrun.
- Underrun: drop in_valid_i for one boundary. Expect TRAIN_PATTERN 8'hA5 serialized, underrun_o pulses once, and the next valid word follows unaltered.
- Slip: pulse slip_i mid-word. Expect the next boundary to be stretched by 1 cycle (repeated bit), so word_start_o spacing becomes 9 once. Data content is unchanged. A second slip_i during pending produces no extra stretch.
- Enable/reset: hold en_i low for 5 cycles mid-word, and all outputs freeze. Assert RST_N low mid-word, and all outputs go 0 immediately and training restarts after release.
- PRBS (macro defined): prbs_sel_i=1 in RUN. Expect the first bytes to match a golden PRBS-7 model from seed 7'h7F, in_ready_o=0 throughout.

Source files
------------

// File: rtl/adc_lvds_pkg.sv
// Shared constants and types for the ADC LVDS word serializer.
// The PRBS-7 items are only consumed when ADC_TX_PRBS_EN is defined.
package adc_lvds_pkg;

  localparam int         WORD_W_DEF        = 8;
  localparam logic [7:0] FRAME_PATTERN_DEF = 8'hF0;
  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hA5;
  localparam int         TRAIN_WORDS_DEF   = 16;

  typedef enum logic {
    ST_TRAIN = 1'b0,
    ST_RUN   = 1'b1
  } tx_state_e;

  // x^7 + x^6 + 1: feedback taps are bits 6 and 5 of the shift state
  localparam logic [6:0] PRBS7_TAPS = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  function automatic logic prbs7_fb(input logic [6:0] s);
    return ^(s & PRBS7_TAPS);
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// Parallel PRBS-7 source: word_o holds the next WORD_W bits, MSB first.
// The LFSR advances by WORD_W steps only when adv_i is high.
module prbs7_gen
  import adc_lvds_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  output logic [WORD_W-1:0] word_o
);

  logic [6:0] lfsr_q, lfsr_d, walk;

  always_comb begin
    walk   = lfsr_q;
    word_o = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      word_o[i] = prbs7_fb(walk);
      walk      = {walk[5:0], word_o[i]};
    end
    lfsr_d = adv_i ? walk : lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= PRBS7_SEED;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/adc_lvds_word_serializer.sv
// MSB-first word serializer with frame line, training, idle fill and bitslip stretch.
// Define ADC_TX_PRBS_EN to add prbs_sel_i and a PRBS-7 payload source in RUN.
module adc_lvds_word_serializer
  import adc_lvds_pkg::*;
#(
  parameter int         WORD_W        = WORD_W_DEF,
  parameter logic [7:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
  parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int         TRAIN_WORDS   = TRAIN_WORDS_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              en_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              slip_i,
`ifdef ADC_TX_PRBS_EN
  input  logic              prbs_sel_i,
`endif
  output logic              sdata_o,
  output logic              frame_o,
  output logic              word_start_o,
  output logic              train_done_o,
  output logic              underrun_o
);

  localparam int CW  = $clog2(WORD_W);
  localparam int TCW = (TRAIN_WORDS > 0) ? $clog2(TRAIN_WORDS + 1) : 1;
  localparam logic [CW-1:0]     LAST_BIT  = CW'(WORD_W - 1);
  localparam logic [TCW-1:0]    TRAIN_END = TCW'(TRAIN_WORDS);
  localparam logic [WORD_W-1:0] FRAME_W   = FRAME_PATTERN[WORD_W-1:0];
  localparam logic [WORD_W-1:0] TRAIN_W   = TRAIN_PATTERN[WORD_W-1:0];

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0]    train_cnt_q, train_cnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d, freg_q, freg_d;
  logic              sdata_q, sdata_d, frame_q, frame_d;
  logic              ws_q, ws_d, rdy_q, rdy_d, done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              slip_pend_q, slip_pend_d, first_run_q, first_run_d;

  logic              cand, bnd, stretch, run_now, prbs_mode, xfer;
  logic [WORD_W-1:0] word;
  logic              prbs_sel;
  logic [WORD_W-1:0] prbs_word;

  assign cand    = (bit_cnt_q == LAST_BIT);
  assign bnd     = en_i & cand & ~slip_pend_q;
  assign stretch = en_i & cand & slip_pend_q;
  // TRAIN_WORDS == 0 makes the very first boundary a RUN boundary
  assign run_now = (state_q == ST_RUN) | (train_cnt_q == TRAIN_END);

`ifdef ADC_TX_PRBS_EN
  logic prbs_adv;
  assign prbs_sel = prbs_sel_i;
  assign prbs_adv = bnd & run_now & prbs_sel;
  prbs7_gen #(.WORD_W(WORD_W)) u_prbs (
    .clk    (CLK),
    .rst_n  (RST_N),
    .adv_i  (prbs_adv),
    .word_o (prbs_word)
  );
`else
  assign prbs_sel  = 1'b0;
  assign prbs_word = '0;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    train_cnt_d = train_cnt_q;
    sreg_d      = sreg_q;
    freg_d      = freg_q;
    sdata_d     = sdata_q;
    frame_d     = frame_q;
    ws_d        = ws_q;
    rdy_d       = rdy_q;
    done_d      = done_q;
    underrun_d  = underrun_q;
    slip_pend_d = slip_pend_q;
    first_run_d = first_run_q;

    prbs_mode = run_now & prbs_sel;
    xfer      = bnd & run_now & ~prbs_mode & in_valid_i & rdy_q;
    word      = TRAIN_W;
    if (prbs_mode)  word = prbs_word;
    else if (xfer)  word = in_data_i;

    if (en_i) begin
      slip_pend_d = slip_pend_q ? ~stretch : slip_i;
      ws_d        = 1'b0;
      underrun_d  = 1'b0;
      if (bnd) begin
        sdata_d   = word[WORD_W-1];
        sreg_d    = {word[WORD_W-2:0], 1'b0};
        frame_d   = FRAME_W[WORD_W-1];
        freg_d    = {FRAME_W[WORD_W-2:0], 1'b0};
        bit_cnt_d = '0;
        ws_d      = 1'b1;
        if (run_now) begin
          state_d     = ST_RUN;
          first_run_d = 1'b0;
          underrun_d  = ~prbs_mode & ~xfer & ~first_run_q;
        end else begin
          train_cnt_d = train_cnt_q + 1'b1;
        end
      end else if (!stretch) begin
        sdata_d   = sreg_q[WORD_W-1];
        sreg_d    = sreg_q << 1;
        frame_d   = freg_q[WORD_W-1];
        freg_d    = freg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      // ready is registered, so predict whether the next cycle is a RUN boundary
      rdy_d  = (bit_cnt_d == LAST_BIT) & ~slip_pend_d & ~prbs_sel &
               ((state_d == ST_RUN) | (train_cnt_d == TRAIN_END));
      done_d = done_q | rdy_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_TRAIN;
      bit_cnt_q   <= LAST_BIT;
      train_cnt_q <= '0;
      sreg_q      <= '0;
      freg_q      <= '0;
      sdata_q     <= 1'b0;
      frame_q     <= 1'b0;
      ws_q        <= 1'b0;
      rdy_q       <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      slip_pend_q <= 1'b0;
      first_run_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      train_cnt_q <= train_cnt_d;
      sreg_q      <= sreg_d;
      freg_q      <= freg_d;
      sdata_q     <= sdata_d;
      frame_q     <= frame_d;
      ws_q        <= ws_d;
      rdy_q       <= rdy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      slip_pend_q <= slip_pend_d;
      first_run_q <= first_run_d;
    end
  end

  assign in_ready_o   = rdy_q & en_i;
  assign sdata_o      = sdata_q;
  assign frame_o      = frame_q;
  assign word_start_o = ws_q;
  assign train_done_o = done_q;
  assign underrun_o   = underrun_q;

endmodule
